silent_step_sequencer: RTL and testbench
========================================

# silent_step_sequencer

Sequencer between the drive-data RAM and `step_calculator` in the silencer path. On each drive update it latches the silencer configuration into shadow registers, fetches `DEPTH` intensity/phase samples from the drive RAM, and presents them to the calculator with the required `DIN_VALID` alignment. It then counts the calculator's `DOUT_VALID` beats to detect frame completion, and queues or flags update requests that arrive while a frame is in flight.

## Interface
- `DEPTH`, 249, transducers per frame; it is also the RAM address range.
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `UPDATE`  in  1  single-cycle drive-update request.
- `CFG_UPDATE_RATE_INTENSITY`, `CFG_UPDATE_RATE_PHASE`  in  16 each  fixed-mode update rates from the config bank.
- `CFG_COMPLETION_STEPS_INTENSITY`, `CFG_COMPLETION_STEPS_PHASE`  in  16 each  completion steps from the config bank.
- `CFG_FIXED_COMPLETION_STEPS`  in  1  selects completion-steps mode.
- `RAM_ADDR`  out  `$clog2(DEPTH)`  drive RAM read address; read latency is 1 cycle.
- `RAM_INTENSITY`  in  16  RAM read data.
- `RAM_PHASE`  in  8  RAM read data.
- `DIN_VALID`  out  1  frame start to the calculator.
- `INTENSITY_IN`  out  16  sample stream to the calculator.
- `PHASE_IN`  out  8  sample stream to the calculator.
- `UPDATE_RATE_INTENSITY_FIXED`, `UPDATE_RATE_PHASE_FIXED`, `COMPLETION_STEPS_INTENSITY_S`, `COMPLETION_STEPS_PHASE_S`  out  16 each  shadowed config to the calculator.
- `FIXED_COMPLETION_STEPS_S`  out  1  shadowed config to the calculator.
- `CALC_DOUT_VALID`  in  1  calculator output-beat strobe.
- `BUSY`  out  1  high from frame accept until the last output beat.
- `OVERRUN`  out  1  sticky flag, set when an update is dropped; cleared only by reset.
- `ZERO_STEPS`  out  1  sticky flag, set when a zero completion-step value was clamped.

## Operation
- States:
  - `IDLE`: wait for an update.
  - `FETCH`: prime the RAM read.
  - `STREAM`: present `DEPTH` samples.
  - `DRAIN`: wait for calculator output beats.
- Frame start, `IDLE` -> `FETCH`:
  - Trigger is `UPDATE` or a pending request.
  - On the transition, latch all `CFG_*` inputs into the shadow outputs and set `RAM_ADDR`=0.
  - Any completion-steps value of 0 is shadowed as 1 and sets `ZERO_STEPS`.
- `FETCH` -> `STREAM`: unconditional, after 1 cycle; `RAM_ADDR` advances to 1.
- `STREAM`:
  - The sample counter `k` runs 0..`DEPTH`-1.
  - `INTENSITY_IN`/`PHASE_IN` carry RAM data for index `k`.
  - `DIN_VALID`=1 only when `k`=0.
  - `RAM_ADDR`=`k`+1, saturating at `DEPTH`-1.
  - After `k`=`DEPTH`-1 -> `DRAIN`.
- Beat counter:
  - Counts `CALC_DOUT_VALID`, width `$clog2(DEPTH+1)`.
  - Is cleared at frame start.
  - Counts in `STREAM` and `DRAIN`.
- `DRAIN` -> `IDLE`: when the beat count reaches `DEPTH`.
- `BUSY`=1 in all states except `IDLE`.
- Pending request (one deep):
  - `UPDATE` in any state other than `IDLE` sets `pending`.
  - `UPDATE` while `pending` is already set keeps it set and sets `OVERRUN`.
  - From `IDLE`, `pending` starts the next frame and clears in the same cycle.
  - Completion and a new `UPDATE` in the same cycle (`DRAIN` -> `IDLE` plus `UPDATE`): `pending` is set, and the next frame starts from `IDLE` one cycle later.
- Shadow registers change only at frame start. `CFG_*` changes mid-frame have no effect until the next frame.
- Outside `STREAM`, `INTENSITY_IN`/`PHASE_IN` hold 0.

## Timing
- Reset values:
  - state `IDLE`, `RAM_ADDR`=0.
  - `DIN_VALID`=0, `INTENSITY_IN`=0, `PHASE_IN`=0.
  - All shadows 0 except the completion steps, which reset to 1.
  - `BUSY`=0, `pending`=0, `OVERRUN`=0, `ZERO_STEPS`=0.
- Reset mid-frame: immediate return to the reset values. Any partial calculator frame is abandoned; the calculator recovers by itself because its frame length is fixed.
- `UPDATE` in cycle t0 while `IDLE`:
  - `BUSY` is high from t0+1.
  - `DIN_VALID` is high in t0+2, together with sample 0.
  - Sample k is presented in t0+2+k.
  - The final sample is in t0+1+`DEPTH`.
- `DIN_VALID` and sample 0 are always in the same cycle; the calculator registers both on the same edge.
- Frame period is `DEPTH`+2 cycles plus calculator latency. The minimum gap between frames is 1 `IDLE` cycle.
- All outputs are registered.

## Structure
- Place the `state_t` enum (`IDLE`, `FETCH`, `STREAM`, `DRAIN`) and the `DEPTH`-derived width localparams in the silencer package, shared with `step_calculator`'s testbench.
- Natural single sub-module: `silent_cfg_shadow`. It owns the config latching, zero clamp and `ZERO_STEPS` flag, with a `LOAD` strobe input.
- The top level holds the FSM, counters and pending/overrun logic.

## Test plan
- Single update, `DEPTH`=4, RAM[i]=(0x100·i, i):
  - `DIN_VALID` in t0+2 only.
  - Samples 0x000, 0x100, 0x200, 0x300 appear in t0+2..t0+5.
  - After 4 `CALC_DOUT_VALID` beats, `BUSY` falls.
- Config shadowing: set `CFG_COMPLETION_STEPS_INTENSITY`=10 and pulse `UPDATE`, then change it to 20 mid-frame -> `COMPLETION_STEPS_INTENSITY_S` stays 10 until the next frame start, then becomes 20.
- Zero clamp: `CFG_COMPLETION_STEPS_PHASE`=0 -> `COMPLETION_STEPS_PHASE_S`=1 and `ZERO_STEPS`=1, which persists until `RST`.
- Back-to-back: a second `UPDATE` during `STREAM` -> a second frame starts 1 cycle after the first frame completes, and `OVERRUN` stays 0.
- Third `UPDATE` while `pending` -> `OVERRUN`=1, and exactly two frames are produced.
- Reset mid-`STREAM` (k=2) -> next cycle `BUSY`=0, `DIN_VALID`=0, samples are 0. A subsequent `UPDATE` produces a clean full frame from sample 0.

Source files
------------

// File: rtl/silent_step_sequencer_pkg.sv
// Shared types and sizing for the silencer drive path: sequencer states,
// shadowed configuration layout and the zero completion-step clamp.
package silent_step_sequencer_pkg;
   localparam int SEQ_DEPTH  = 249;
   localparam int SEQ_ADDR_W = $clog2(SEQ_DEPTH);
   localparam int SEQ_CNT_W  = $clog2(SEQ_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   typedef struct packed {
      logic [15:0] rate_intensity;
      logic [15:0] rate_phase;
      logic [15:0] steps_intensity;
      logic [15:0] steps_phase;
      logic        fixed_steps;
   } cfg_t;

   localparam cfg_t CFG_RESET = '{
      rate_intensity:  16'd0,
      rate_phase:      16'd0,
      steps_intensity: 16'd1,
      steps_phase:     16'd1,
      fixed_steps:     1'b0
   };

   // A zero step count would stall the calculator, so it is replaced by 1.
   function automatic logic [15:0] clamp_steps(input logic [15:0] v);
      return (v == 16'd0) ? 16'd1 : v;
   endfunction
endpackage

// File: rtl/silent_step_sequencer_if.sv
// Bundle between the sequencer, the drive RAM, the config bank and step_calculator.
interface silent_step_sequencer_if #(
   parameter int DEPTH = silent_step_sequencer_pkg::SEQ_DEPTH
);
   import silent_step_sequencer_pkg::*;
   localparam int ADDR_W = $clog2(DEPTH);

   // UPDATE is a one-cycle request without ready (one extra request queues, more set OVERRUN);
   // DIN_VALID marks sample 0, samples 1..DEPTH-1 follow on consecutive cycles;
   // CALC_DOUT_VALID is a per-beat strobe with no backpressure.
   logic              UPDATE;
   logic [15:0]       CFG_UPDATE_RATE_INTENSITY;
   logic [15:0]       CFG_UPDATE_RATE_PHASE;
   logic [15:0]       CFG_COMPLETION_STEPS_INTENSITY;
   logic [15:0]       CFG_COMPLETION_STEPS_PHASE;
   logic              CFG_FIXED_COMPLETION_STEPS;
   logic [ADDR_W-1:0] RAM_ADDR;
   logic [15:0]       RAM_INTENSITY;
   logic [7:0]        RAM_PHASE;
   logic              DIN_VALID;
   logic [15:0]       INTENSITY_IN;
   logic [7:0]        PHASE_IN;
   logic [15:0]       UPDATE_RATE_INTENSITY_FIXED;
   logic [15:0]       UPDATE_RATE_PHASE_FIXED;
   logic [15:0]       COMPLETION_STEPS_INTENSITY_S;
   logic [15:0]       COMPLETION_STEPS_PHASE_S;
   logic              FIXED_COMPLETION_STEPS_S;
   logic              CALC_DOUT_VALID;
   logic              BUSY;
   logic              OVERRUN;
   logic              ZERO_STEPS;
   state_t            STATE;

   modport seq (
      input  UPDATE, CFG_UPDATE_RATE_INTENSITY, CFG_UPDATE_RATE_PHASE,
             CFG_COMPLETION_STEPS_INTENSITY, CFG_COMPLETION_STEPS_PHASE,
             CFG_FIXED_COMPLETION_STEPS, RAM_INTENSITY, RAM_PHASE, CALC_DOUT_VALID,
      output RAM_ADDR, DIN_VALID, INTENSITY_IN, PHASE_IN,
             UPDATE_RATE_INTENSITY_FIXED, UPDATE_RATE_PHASE_FIXED,
             COMPLETION_STEPS_INTENSITY_S, COMPLETION_STEPS_PHASE_S,
             FIXED_COMPLETION_STEPS_S, BUSY, OVERRUN, ZERO_STEPS, STATE
   );

   modport env (
      output UPDATE, CFG_UPDATE_RATE_INTENSITY, CFG_UPDATE_RATE_PHASE,
             CFG_COMPLETION_STEPS_INTENSITY, CFG_COMPLETION_STEPS_PHASE,
             CFG_FIXED_COMPLETION_STEPS, RAM_INTENSITY, RAM_PHASE, CALC_DOUT_VALID,
      input  RAM_ADDR, DIN_VALID, INTENSITY_IN, PHASE_IN,
             UPDATE_RATE_INTENSITY_FIXED, UPDATE_RATE_PHASE_FIXED,
             COMPLETION_STEPS_INTENSITY_S, COMPLETION_STEPS_PHASE_S,
             FIXED_COMPLETION_STEPS_S, BUSY, OVERRUN, ZERO_STEPS, STATE
   );
endinterface

// File: rtl/silent_step_sequencer_cfg_shadow.sv
// Shadow copy of the silencer configuration, captured on LOAD so a frame
// always runs with one consistent set of rates and completion steps.
module silent_cfg_shadow
   import silent_step_sequencer_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        LOAD,
   input  logic [15:0] CFG_UPDATE_RATE_INTENSITY,
   input  logic [15:0] CFG_UPDATE_RATE_PHASE,
   input  logic [15:0] CFG_COMPLETION_STEPS_INTENSITY,
   input  logic [15:0] CFG_COMPLETION_STEPS_PHASE,
   input  logic        CFG_FIXED_COMPLETION_STEPS,
   output logic [15:0] UPDATE_RATE_INTENSITY_FIXED,
   output logic [15:0] UPDATE_RATE_PHASE_FIXED,
   output logic [15:0] COMPLETION_STEPS_INTENSITY_S,
   output logic [15:0] COMPLETION_STEPS_PHASE_S,
   output logic        FIXED_COMPLETION_STEPS_S,
   output logic        ZERO_STEPS
);
   cfg_t shadow_q, shadow_d;
   logic zero_steps_q, zero_steps_d;

   always_comb begin
      shadow_d     = shadow_q;
      zero_steps_d = zero_steps_q;
      if (LOAD) begin
         shadow_d.rate_intensity  = CFG_UPDATE_RATE_INTENSITY;
         shadow_d.rate_phase      = CFG_UPDATE_RATE_PHASE;
         shadow_d.steps_intensity = clamp_steps(CFG_COMPLETION_STEPS_INTENSITY);
         shadow_d.steps_phase     = clamp_steps(CFG_COMPLETION_STEPS_PHASE);
         shadow_d.fixed_steps     = CFG_FIXED_COMPLETION_STEPS;
         zero_steps_d = zero_steps_q
                        | (CFG_COMPLETION_STEPS_INTENSITY == 16'd0)
                        | (CFG_COMPLETION_STEPS_PHASE == 16'd0);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shadow_q     <= CFG_RESET;
         zero_steps_q <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         zero_steps_q <= zero_steps_d;
      end
   end

   assign UPDATE_RATE_INTENSITY_FIXED  = shadow_q.rate_intensity;
   assign UPDATE_RATE_PHASE_FIXED      = shadow_q.rate_phase;
   assign COMPLETION_STEPS_INTENSITY_S = shadow_q.steps_intensity;
   assign COMPLETION_STEPS_PHASE_S     = shadow_q.steps_phase;
   assign FIXED_COMPLETION_STEPS_S     = shadow_q.fixed_steps;
   assign ZERO_STEPS                   = zero_steps_q;
endmodule

// File: rtl/silent_step_sequencer.sv
// Drive-update sequencer: fetches DEPTH intensity/phase samples from the drive RAM,
// streams them to step_calculator and counts its output beats to detect frame end.
module silent_step_sequencer #(
   parameter int DEPTH = silent_step_sequencer_pkg::SEQ_DEPTH
) (
   input logic CLK,
   input logic RST,
   silent_step_sequencer_if.seq bus
);
   import silent_step_sequencer_pkg::*;

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_K     = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   LAST_K_W   = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_BEATS = CNT_W'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] k_q, k_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   addr_step;
   logic [CNT_W-1:0]  beat_q, beat_d;
   logic              din_valid_q, din_valid_d;
   logic [15:0]       intensity_q, intensity_d;
   logic [7:0]        phase_q, phase_d;
   logic              pending_q, pending_d;
   logic              overrun_q, overrun_d;
   logic              busy_q, busy_d;
   logic              load;

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      addr_d    = addr_q;
      beat_d    = beat_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      load      = 1'b0;
      addr_step = {1'b0, k_q} + (ADDR_W + 1)'(2);

      if ((state_q == STREAM || state_q == DRAIN) && bus.CALC_DOUT_VALID && beat_q != FULL_BEATS)
         beat_d = beat_q + 1'b1;

      // Requests arriving mid-frame queue one deep; a second one is dropped and flagged.
      if (state_q != IDLE && bus.UPDATE) begin
         pending_d = 1'b1;
         if (pending_q) overrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (bus.UPDATE || pending_q) begin
               load      = 1'b1;
               pending_d = 1'b0;
               state_d   = FETCH;
               addr_d    = '0;
               beat_d    = '0;
            end
         end
         FETCH: begin
            state_d = STREAM;
            k_d     = '0;
            addr_d  = ADDR_W'(1);
         end
         STREAM: begin
            if (k_q == LAST_K) state_d = DRAIN;
            else               k_d = k_q + 1'b1;
            addr_d = (addr_step > LAST_K_W) ? LAST_K : addr_step[ADDR_W-1:0];
         end
         DRAIN: begin
            if (beat_d == FULL_BEATS) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // RAM data for the address held this cycle is captured into the sample register,
      // which is what places sample k one cycle behind RAM_ADDR = k.
      busy_d      = (state_d != IDLE);
      din_valid_d = (state_q == FETCH);
      intensity_d = (state_d == STREAM) ? bus.RAM_INTENSITY : 16'd0;
      phase_d     = (state_d == STREAM) ? bus.RAM_PHASE : 8'd0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         k_q         <= '0;
         addr_q      <= '0;
         beat_q      <= '0;
         din_valid_q <= 1'b0;
         intensity_q <= 16'd0;
         phase_q     <= 8'd0;
         pending_q   <= 1'b0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         addr_q      <= addr_d;
         beat_q      <= beat_d;
         din_valid_q <= din_valid_d;
         intensity_q <= intensity_d;
         phase_q     <= phase_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         busy_q      <= busy_d;
      end
   end

   silent_cfg_shadow u_cfg_shadow (
      .CLK                            (CLK),
      .RST                            (RST),
      .LOAD                           (load),
      .CFG_UPDATE_RATE_INTENSITY      (bus.CFG_UPDATE_RATE_INTENSITY),
      .CFG_UPDATE_RATE_PHASE          (bus.CFG_UPDATE_RATE_PHASE),
      .CFG_COMPLETION_STEPS_INTENSITY (bus.CFG_COMPLETION_STEPS_INTENSITY),
      .CFG_COMPLETION_STEPS_PHASE     (bus.CFG_COMPLETION_STEPS_PHASE),
      .CFG_FIXED_COMPLETION_STEPS     (bus.CFG_FIXED_COMPLETION_STEPS),
      .UPDATE_RATE_INTENSITY_FIXED    (bus.UPDATE_RATE_INTENSITY_FIXED),
      .UPDATE_RATE_PHASE_FIXED        (bus.UPDATE_RATE_PHASE_FIXED),
      .COMPLETION_STEPS_INTENSITY_S   (bus.COMPLETION_STEPS_INTENSITY_S),
      .COMPLETION_STEPS_PHASE_S       (bus.COMPLETION_STEPS_PHASE_S),
      .FIXED_COMPLETION_STEPS_S       (bus.FIXED_COMPLETION_STEPS_S),
      .ZERO_STEPS                     (bus.ZERO_STEPS)
   );

   assign bus.RAM_ADDR     = addr_q;
   assign bus.DIN_VALID    = din_valid_q;
   assign bus.INTENSITY_IN = intensity_q;
   assign bus.PHASE_IN     = phase_q;
   assign bus.BUSY         = busy_q;
   assign bus.OVERRUN      = overrun_q;
   assign bus.STATE        = state_q;
endmodule

// File: tb/tb_silent_step_sequencer.sv
// Directed bench for silent_step_sequencer with DEPTH=4 and RAM[i] = (0x100*i, i).
module tb_silent_step_sequencer;
   import silent_step_sequencer_pkg::*;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   frames   = 0;
   bit   in_frame = 1'b0;
   int   mk       = 0;
   logic [23:0] exp_q[$];
   logic [15:0] ram_int [DEPTH];
   logic [7:0]  ram_ph  [DEPTH];

   silent_step_sequencer_if #(.DEPTH(DEPTH)) bus ();

   silent_step_sequencer #(.DEPTH(DEPTH)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   // clock / reset
   always #5 clk = ~clk;

   // drive RAM: read data follows RAM_ADDR combinationally
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram_int[i] = 16'(i * 256);
         ram_ph[i]  = 8'(i);
      end
   end
   assign bus.RAM_INTENSITY = ram_int[bus.RAM_ADDR];
   assign bus.RAM_PHASE     = ram_ph[bus.RAM_ADDR];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame();
      exp_q.push_back({16'h0000, 8'h00});
      exp_q.push_back({16'h0100, 8'h01});
      exp_q.push_back({16'h0200, 8'h02});
      exp_q.push_back({16'h0300, 8'h03});
   endtask

   // Runs one frame from cycle t0 (c=0) to the first IDLE cycle t0+10; calculator
   // beats are driven in t0+6..t0+9. extra_upd[c] raises UPDATE in cycle t0+c.
   task automatic run_frame(input bit trig, input logic [9:0] extra_upd,
                            input logic [15:0] exp_si, input logic [15:0] new_si);
      push_frame();
      for (int c = 0; c < 10; c++) begin
         bus.UPDATE          = (trig && c == 0) || extra_upd[c];
         bus.CALC_DOUT_VALID = (c >= 6);
         if (c == 3) bus.CFG_COMPLETION_STEPS_INTENSITY = new_si;
         case (c)
            0: check("busy_before", 32'(bus.BUSY), 0);
            1: begin
               check("busy_t1", 32'(bus.BUSY), 1);
               check("state_fetch", 32'(bus.STATE), 32'(FETCH));
               check("ram_addr_t1", 32'(bus.RAM_ADDR), 0);
               check("steps_int_s_t1", 32'(bus.COMPLETION_STEPS_INTENSITY_S), 32'(exp_si));
            end
            2: begin
               check("ram_addr_t2", 32'(bus.RAM_ADDR), 1);
               check("state_stream", 32'(bus.STATE), 32'(STREAM));
            end
            5: check("ram_addr_sat", 32'(bus.RAM_ADDR), DEPTH - 1);
            6: check("state_drain", 32'(bus.STATE), 32'(DRAIN));
            9: begin
               check("busy_last_beat", 32'(bus.BUSY), 1);
               check("steps_int_s_t9", 32'(bus.COMPLETION_STEPS_INTENSITY_S), 32'(exp_si));
            end
            default: ;
         endcase
         step();
      end
      bus.UPDATE          = 1'b0;
      bus.CALC_DOUT_VALID = 1'b0;
      check("busy_done", 32'(bus.BUSY), 0);
      check("state_idle", 32'(bus.STATE), 32'(IDLE));
   endtask

   // scoreboard: every streamed sample is matched against exp_q
   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
         mk       = 0;
      end else begin
         if (!in_frame && bus.DIN_VALID) begin
            in_frame = 1'b1;
            mk       = 0;
            frames++;
         end
         if (in_frame) begin
            check("din_valid_align", 32'(bus.DIN_VALID), 32'(mk == 0));
            check("frame_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0)
               check("sample", {8'h00, bus.INTENSITY_IN, bus.PHASE_IN}, {8'h00, exp_q.pop_front()});
            mk++;
            if (mk == DEPTH) in_frame = 1'b0;
         end else begin
            check("idle_sample", {8'h00, bus.INTENSITY_IN, bus.PHASE_IN}, 0);
         end
      end
   end

   initial begin
      int f0;
      bus.UPDATE                         = 1'b0;
      bus.CALC_DOUT_VALID                = 1'b0;
      bus.CFG_UPDATE_RATE_INTENSITY      = 16'h1234;
      bus.CFG_UPDATE_RATE_PHASE          = 16'h5678;
      bus.CFG_COMPLETION_STEPS_INTENSITY = 16'd10;
      bus.CFG_COMPLETION_STEPS_PHASE     = 16'd7;
      bus.CFG_FIXED_COMPLETION_STEPS     = 1'b1;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();

      // reset values
      check("rst_ram_addr", 32'(bus.RAM_ADDR), 0);
      check("rst_din_valid", 32'(bus.DIN_VALID), 0);
      check("rst_intensity", 32'(bus.INTENSITY_IN), 0);
      check("rst_phase", 32'(bus.PHASE_IN), 0);
      check("rst_rate_int", 32'(bus.UPDATE_RATE_INTENSITY_FIXED), 0);
      check("rst_rate_ph", 32'(bus.UPDATE_RATE_PHASE_FIXED), 0);
      check("rst_steps_int", 32'(bus.COMPLETION_STEPS_INTENSITY_S), 1);
      check("rst_steps_ph", 32'(bus.COMPLETION_STEPS_PHASE_S), 1);
      check("rst_fixed", 32'(bus.FIXED_COMPLETION_STEPS_S), 0);
      check("rst_busy", 32'(bus.BUSY), 0);
      check("rst_overrun", 32'(bus.OVERRUN), 0);
      check("rst_zero", 32'(bus.ZERO_STEPS), 0);
      check("rst_state", 32'(bus.STATE), 32'(IDLE));

      // single frame, intensity steps changed from 10 to 20 mid-frame
      run_frame(1'b1, 10'd0, 16'd10, 16'd20);
      check("shadow_held", 32'(bus.COMPLETION_STEPS_INTENSITY_S), 10);
      check("shadow_rate_int", 32'(bus.UPDATE_RATE_INTENSITY_FIXED), 32'h1234);
      check("shadow_rate_ph", 32'(bus.UPDATE_RATE_PHASE_FIXED), 32'h5678);
      check("shadow_steps_ph", 32'(bus.COMPLETION_STEPS_PHASE_S), 7);
      check("shadow_fixed", 32'(bus.FIXED_COMPLETION_STEPS_S), 1);

      // zero clamp plus a queued second request during STREAM
      bus.CFG_COMPLETION_STEPS_PHASE = 16'd0;
      run_frame(1'b1, 10'b0000001000, 16'd20, 16'd20);
      check("clamp_steps_ph", 32'(bus.COMPLETION_STEPS_PHASE_S), 1);
      check("zero_steps_set", 32'(bus.ZERO_STEPS), 1);
      bus.CFG_COMPLETION_STEPS_PHASE = 16'd5;
      run_frame(1'b0, 10'd0, 16'd20, 16'd20);
      check("b2b_steps_ph", 32'(bus.COMPLETION_STEPS_PHASE_S), 5);
      check("zero_steps_sticky", 32'(bus.ZERO_STEPS), 1);
      check("b2b_no_overrun", 32'(bus.OVERRUN), 0);

      // third request while pending: overrun, exactly two frames
      f0 = frames;
      run_frame(1'b1, 10'b0000101000, 16'd20, 16'd20);
      check("overrun_set", 32'(bus.OVERRUN), 1);
      run_frame(1'b0, 10'd0, 16'd20, 16'd20);
      repeat (6) step();
      check("overrun_frames", 32'(frames - f0), 2);
      check("overrun_queue_empty", 32'(exp_q.size()), 0);
      check("overrun_sticky", 32'(bus.OVERRUN), 1);

      // request in the completion cycle starts the next frame after one IDLE cycle
      run_frame(1'b1, 10'b1000000000, 16'd20, 16'd20);
      run_frame(1'b0, 10'd0, 16'd20, 16'd20);

      // reset in STREAM at k=2
      push_frame();
      bus.UPDATE = 1'b1;
      step();
      bus.UPDATE = 1'b0;
      step();
      step();
      step();
      check("pre_reset_state", 32'(bus.STATE), 32'(STREAM));
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("mid_rst_busy", 32'(bus.BUSY), 0);
      check("mid_rst_din", 32'(bus.DIN_VALID), 0);
      check("mid_rst_int", 32'(bus.INTENSITY_IN), 0);
      check("mid_rst_ph", 32'(bus.PHASE_IN), 0);
      step();
      check("mid_rst_state", 32'(bus.STATE), 32'(IDLE));
      check("mid_rst_overrun", 32'(bus.OVERRUN), 0);
      check("mid_rst_zero", 32'(bus.ZERO_STEPS), 0);
      check("mid_rst_steps_ph", 32'(bus.COMPLETION_STEPS_PHASE_S), 1);
      rst = 1'b0;
      step();
      run_frame(1'b1, 10'd0, 16'd20, 16'd20);
      check("post_rst_zero", 32'(bus.ZERO_STEPS), 0);
      check("post_rst_overrun", 32'(bus.OVERRUN), 0);
      repeat (4) step();
      check("final_queue_empty", 32'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
